fifo_scsi_unpacker: RTL and testbench
=====================================

Name: fifo_scsi_unpacker

Overview:
- Read-side drain for the 8-entry 32-bit DMA FIFO when data moves from memory to SCSI.
- Pops one longword from the FIFO output and unpacks it big-endian into four bytes.
- Presents each byte to the SCSI controller with a DREQ/DACK byte handshake.
- Sits between the FIFO read port (OD, empty flag, out-pointer increment) and the SCSI peripheral data bus.

Parameters:
- DACK_CYCLES, 2: number of SCLK cycles DACK is held high per byte; legal range 1..15.

Ports:
- SCLK  input  1  system clock; all logic on rising edge.
- RST  input  1  synchronous, active-high reset.
- ENABLE  input  1  DMA active, direction memory->SCSI.
- FLUSH  input  1  synchronous discard of any held longword.
- FIFOEMPTY  input  1  FIFO has no longword available.
- FIFO_OD  input  32  FIFO output data at the current out-pointer.
- INCNO  output  1  one-cycle pulse; advances the FIFO out-pointer.
- DECFIFO  output  1  one-cycle pulse; decrements the FIFO occupancy; always coincident with INCNO.
- DREQ  input  1  SCSI controller requests a byte.
- PD  output  8  byte to the SCSI controller.
- DACK  output  1  byte strobe to the SCSI controller.
- BO  output  2  byte offset of the byte currently presented.
- BOEQ3  output  1  high when BO==3.
- BUSY  output  1  high whenever state is not IDLE.

Behaviour:
- Interface: one clock, SCLK. Reset RST is synchronous and active-high. All outputs are registered.
- Reset values: state=IDLE, PD=8'h00, DACK=0, INCNO=0, DECFIFO=0, BO=0, BOEQ3=0, BUSY=0, holding register=0, strobe counter=0.
- FSM states: IDLE, LOAD, WAIT_REQ, STROBE, RECOVER.
- IDLE -> LOAD when ENABLE=1 and FIFOEMPTY=0.
- LOAD (one cycle):
  - INCNO=DECFIFO=1 for exactly this cycle.
  - Holding register <= FIFO_OD and BO <= 0 on the edge ending LOAD.
  - Next state: WAIT_REQ.
- PD mapping (combinational select from the holding register, registered onto PD):
  - BO=0 -> [31:24]; BO=1 -> [23:16]; BO=2 -> [15:8]; BO=3 -> [7:0].
  - PD is valid from the first cycle of WAIT_REQ.
  - PD stays stable through STROBE and RECOVER.
- WAIT_REQ -> STROBE when DREQ=1 and ENABLE=1. Otherwise the block holds, keeping the word and BO.
- STROBE:
  - DACK=1 for exactly DACK_CYCLES cycles; the counter is loaded on entry.
  - Then DACK=0 -> RECOVER.
  - ENABLE falling during STROBE does not truncate the strobe.
- RECOVER waits for DREQ=0, then:
  - If BO<3: BO <= BO+1 -> WAIT_REQ.
  - If BO==3: BO <= 0 and the word is consumed. Next state is LOAD if ENABLE=1 and FIFOEMPTY=0, otherwise IDLE.
- Latency:
  - FIFOEMPTY falls in IDLE at cycle n -> LOAD at n+1 -> PD valid at n+2.
  - DREQ sampled high at cycle m in WAIT_REQ -> DACK high for cycles m+1..m+DACK_CYCLES.
- Back-to-back words: there is no IDLE gap. RECOVER at BO==3 goes directly to LOAD, so a full FIFO is drained at one INCNO per 4 bytes.
- FIFO empty after a word: the block returns to IDLE and never pulses INCNO while FIFOEMPTY=1.
- ENABLE low in WAIT_REQ: the partial word is retained. Resuming ENABLE continues at the same BO with no pop.
- FLUSH:
  - Any state except STROBE -> IDLE with BO=0, holding register=0, PD=0.
  - FLUSH in STROBE is latched and applied when the strobe ends, so DACK is never cut short.
  - FLUSH in LOAD still completes that cycle's INCNO/DECFIFO pulse, and the popped word is discarded.
- RST has priority over FLUSH and over every other input in every state. Reset in the middle of a strobe drops DACK on the next edge.
- DREQ already high on entry to WAIT_REQ is legal; STROBE begins on the next cycle.
- DACK and INCNO are never high in the same cycle.

Test Plan:
- Single word: reset, ENABLE=1, FIFO_OD=32'h11223344, FIFOEMPTY 1->0, DREQ held 1, deasserted for one cycle after each DACK.
  -> exactly one INCNO/DECFIFO pulse.
  -> PD sequence 8'h11, 8'h22, 8'h33, 8'h44 with BO 0..3.
  -> BOEQ3 high only on 8'h44.
  -> DACK high 2 cycles per byte.
  -> return to IDLE, BUSY=0.
- Back-to-back: two words, 32'hA0A1A2A3 then 32'hB0B1B2B3, FIFOEMPTY stays 0.
  -> second INCNO occurs in the cycle after RECOVER of byte 8'hA3.
  -> 8 bytes in order with no IDLE cycle between words.
- Pause: ENABLE dropped after the byte with BO=1 is strobed, held low 20 cycles, then raised.
  -> no DACK and no INCNO during the pause.
  -> resumes with BO=2 and the same word's [15:8].
- Flush in strobe: FLUSH pulsed in the middle cycle of STROBE with DACK_CYCLES=3.
  -> DACK stays high the full 3 cycles.
  -> then IDLE, PD=8'h00, BO=0, no further DACK.
- Reset mid-operation: RST high during STROBE.
  -> next edge gives DACK=0, state IDLE, all outputs at reset values.
  -> a subsequent nonempty FIFO triggers a fresh LOAD with BO=0.
- Parameter sweep: DACK_CYCLES=1 and 15.
  -> DACK width is exactly 1 and exactly 15 cycles.
  -> PD is stable for the full width.

Source files
------------

// File: rtl/fifo_scsi_unpacker.sv
// Memory-to-SCSI drain: pops 32-bit longwords from the DMA FIFO and presents
// them big-endian, one byte at a time, over a DREQ/DACK handshake.
module fifo_scsi_unpacker #(
  parameter int unsigned DACK_CYCLES = 2
) (
  input  logic        SCLK,
  input  logic        RST,
  input  logic        ENABLE,
  input  logic        FLUSH,
  input  logic        FIFOEMPTY,
  input  logic [31:0] FIFO_OD,
  output logic        INCNO,
  output logic        DECFIFO,
  input  logic        DREQ,
  output logic [7:0]  PD,
  output logic        DACK,
  output logic [1:0]  BO,
  output logic        BOEQ3,
  output logic        BUSY
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT_REQ,
    STROBE,
    RECOVER
  } state_t;

  state_t              state_q, state_d;
  logic [WORD_W-1:0]   hold_q, hold_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                flush_q, flush_d;
  logic [1:0]          bo_d;
  logic [BYTE_W-1:0]   pd_d;
  logic                dack_d;
  logic                incno_d;

  // Next state, next holding word / byte offset, and next registered outputs
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    flush_d = flush_q;
    bo_d    = BO;

    unique case (state_q)
      IDLE: begin
        if (ENABLE && !FIFOEMPTY) state_d = LOAD;
      end
      LOAD: begin
        hold_d  = FIFO_OD;
        bo_d    = 2'd0;
        state_d = WAIT_REQ;
      end
      WAIT_REQ: begin
        if (DREQ && ENABLE) begin
          state_d = STROBE;
          cnt_d   = CNT_W'(DACK_CYCLES - 1);
        end
      end
      STROBE: begin
        // A flush here is deferred so the strobe always runs its full width
        if (FLUSH) flush_d = 1'b1;
        if (cnt_q == '0) begin
          if (flush_q || FLUSH) begin
            state_d = IDLE;
            bo_d    = 2'd0;
            hold_d  = '0;
            flush_d = 1'b0;
          end else begin
            state_d = RECOVER;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RECOVER: begin
        if (!DREQ) begin
          if (BO != 2'd3) begin
            bo_d    = BO + 2'd1;
            state_d = WAIT_REQ;
          end else begin
            bo_d    = 2'd0;
            hold_d  = '0;
            state_d = (ENABLE && !FIFOEMPTY) ? LOAD : IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (FLUSH && (state_q != STROBE)) begin
      state_d = IDLE;
      bo_d    = 2'd0;
      hold_d  = '0;
      flush_d = 1'b0;
    end

    dack_d  = (state_d == STROBE);
    incno_d = (state_d == LOAD);

    unique case (bo_d)
      2'd0:    pd_d = hold_d[31:24];
      2'd1:    pd_d = hold_d[23:16];
      2'd2:    pd_d = hold_d[15:8];
      default: pd_d = hold_d[7:0];
    endcase
  end

  // State and output registers
  always_ff @(posedge SCLK) begin
    if (RST) begin
      state_q <= IDLE;
      hold_q  <= '0;
      cnt_q   <= '0;
      flush_q <= 1'b0;
      PD      <= '0;
      DACK    <= 1'b0;
      INCNO   <= 1'b0;
      DECFIFO <= 1'b0;
      BO      <= 2'd0;
      BOEQ3   <= 1'b0;
      BUSY    <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
      flush_q <= flush_d;
      PD      <= pd_d;
      DACK    <= dack_d;
      INCNO   <= incno_d;
      DECFIFO <= incno_d;
      BO      <= bo_d;
      BOEQ3   <= (bo_d == 2'd3);
      BUSY    <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_fifo_scsi_unpacker.sv
// Directed bench for fifo_scsi_unpacker; four instances cover DACK_CYCLES of
// 2 (main), 3 (flush-in-strobe), 1 and 15 (width sweep).
module tb_fifo_scsi_unpacker;

  logic        sclk = 1'b0;
  logic        rst;
  logic        enable;
  logic        flush;
  logic        fifoempty;
  logic [31:0] fifo_od;
  logic        dreq;

  logic        incno_w   [4];
  logic        decfifo_w [4];
  logic [7:0]  pd_w      [4];
  logic        dack_w    [4];
  logic [1:0]  bo_w      [4];
  logic        boeq3_w   [4];
  logic        busy_w    [4];

  int checks = 0;
  int errors = 0;
  int incno_cnt [4];
  int dack_cnt  [4];
  int idle_cnt  [4];

  always #5 sclk = ~sclk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    fifo_scsi_unpacker #(
      .DACK_CYCLES((g == 0) ? 2 : (g == 1) ? 3 : (g == 2) ? 1 : 15)
    ) u_dut (
      .SCLK      (sclk),
      .RST       (rst),
      .ENABLE    (enable),
      .FLUSH     (flush),
      .FIFOEMPTY (fifoempty),
      .FIFO_OD   (fifo_od),
      .INCNO     (incno_w[g]),
      .DECFIFO   (decfifo_w[g]),
      .DREQ      (dreq),
      .PD        (pd_w[g]),
      .DACK      (dack_w[g]),
      .BO        (bo_w[g]),
      .BOEQ3     (boeq3_w[g]),
      .BUSY      (busy_w[g])
    );
  end

  // Event counters plus invariants that must hold every cycle
  always @(negedge sclk) begin
    for (int i = 0; i < 4; i++) begin
      if (incno_w[i] === 1'b1) incno_cnt[i]++;
      if (dack_w[i] === 1'b1)  dack_cnt[i]++;
      if (busy_w[i] === 1'b0)  idle_cnt[i]++;
      if (rst === 1'b0 && decfifo_w[i] !== incno_w[i]) begin
        errors++;
        $display("FAIL decfifo_eq_incno inst%0d: decfifo=%b incno=%b", i, decfifo_w[i], incno_w[i]);
      end
      if (dack_w[i] === 1'b1 && incno_w[i] === 1'b1) begin
        errors++;
        $display("FAIL dack_incno_overlap inst%0d at %0t", i, $time);
      end
    end
  end

  task automatic tick();
    @(negedge sclk);
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b0; flush = 1'b0; fifoempty = 1'b1;
    fifo_od = 32'h0; dreq = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      incno_cnt[i] = 0; dack_cnt[i] = 0; idle_cnt[i] = 0;
    end
  endtask

  // Request one byte, check its value/offset and strobe width, then drop DREQ one cycle
  task automatic serve_byte(input int g, input logic [7:0] exp_pd, input logic [1:0] exp_bo,
                            input int width, input string nm);
    int n;
    int w;
    bit stable;
    dreq = 1'b1;
    n = 0;
    while (dack_w[g] !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 60) begin
      errors++;
      $display("FAIL %s dack_timeout: dack=%b after %0d cycles, required 1", nm, dack_w[g], n);
      return;
    end
    checks++;
    if (pd_w[g] !== exp_pd) begin
      errors++;
      $display("FAIL %s pd: got %h, expected %h", nm, pd_w[g], exp_pd);
    end
    checks++;
    if (bo_w[g] !== exp_bo) begin
      errors++;
      $display("FAIL %s bo: got %0d, expected %0d", nm, bo_w[g], exp_bo);
    end
    checks++;
    if (boeq3_w[g] !== (exp_bo == 2'd3)) begin
      errors++;
      $display("FAIL %s boeq3: got %b, expected %b", nm, boeq3_w[g], (exp_bo == 2'd3));
    end
    w = 0;
    stable = 1'b1;
    while (dack_w[g] === 1'b1 && w < 40) begin
      if (pd_w[g] !== exp_pd) stable = 1'b0;
      w++;
      tick();
    end
    checks++;
    if (w != width) begin
      errors++;
      $display("FAIL %s dack_width: got %0d cycles, expected %0d", nm, w, width);
    end
    checks++;
    if (!stable) begin
      errors++;
      $display("FAIL %s pd_stable: pd changed while dack high, expected %h", nm, exp_pd);
    end
    dreq = 1'b0;
    tick();
    dreq = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; flush = 1'b0; fifoempty = 1'b0;
    fifo_od = 32'hDEADBEEF; dreq = 1'b1;
    tick(); tick();
    checks++;
    if (pd_w[0] !== 8'h00) begin errors++; $display("FAIL reset_pd: got %h, expected 00", pd_w[0]); end
    checks++;
    if (dack_w[0] !== 1'b0) begin errors++; $display("FAIL reset_dack: got %b, expected 0", dack_w[0]); end
    checks++;
    if (incno_w[0] !== 1'b0) begin errors++; $display("FAIL reset_incno: got %b, expected 0", incno_w[0]); end
    checks++;
    if (bo_w[0] !== 2'd0 || boeq3_w[0] !== 1'b0) begin
      errors++; $display("FAIL reset_bo: got bo=%0d boeq3=%b, expected 0/0", bo_w[0], boeq3_w[0]);
    end
    checks++;
    if (busy_w[0] !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, expected 0", busy_w[0]); end
  endtask

  task automatic test_single_word();
    do_reset();
    enable = 1'b1; fifo_od = 32'h11223344; fifoempty = 1'b0;
    tick();
    checks++;
    if (incno_w[0] !== 1'b1 || busy_w[0] !== 1'b1) begin
      errors++; $display("FAIL single_load: incno=%b busy=%b, expected 1/1", incno_w[0], busy_w[0]);
    end
    fifoempty = 1'b1;
    tick();
    checks++;
    if (pd_w[0] !== 8'h11 || incno_w[0] !== 1'b0) begin
      errors++; $display("FAIL single_pd_valid: pd=%h incno=%b, expected 11/0", pd_w[0], incno_w[0]);
    end
    dreq = 1'b1;
    tick();
    checks++;
    if (dack_w[0] !== 1'b1) begin
      errors++; $display("FAIL single_dack_latency: dack=%b one cycle after dreq, expected 1", dack_w[0]);
    end
    serve_byte(0, 8'h11, 2'd0, 2, "single_b0");
    serve_byte(0, 8'h22, 2'd1, 2, "single_b1");
    serve_byte(0, 8'h33, 2'd2, 2, "single_b2");
    serve_byte(0, 8'h44, 2'd3, 2, "single_b3");
    dreq = 1'b0;
    tick(); tick();
    checks++;
    if (busy_w[0] !== 1'b0) begin errors++; $display("FAIL single_idle: busy=%b, expected 0", busy_w[0]); end
    checks++;
    if (incno_cnt[0] != 1) begin
      errors++; $display("FAIL single_incno_count: got %0d pulses, expected 1", incno_cnt[0]);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    enable = 1'b1; fifo_od = 32'hA0A1A2A3; fifoempty = 1'b0;
    tick();
    tick();
    fifo_od = 32'hB0B1B2B3;
    idle_cnt[0] = 0;
    serve_byte(0, 8'hA0, 2'd0, 2, "b2b_a0");
    serve_byte(0, 8'hA1, 2'd1, 2, "b2b_a1");
    serve_byte(0, 8'hA2, 2'd2, 2, "b2b_a2");
    serve_byte(0, 8'hA3, 2'd3, 2, "b2b_a3");
    checks++;
    if (incno_w[0] !== 1'b1) begin
      errors++; $display("FAIL b2b_second_incno: incno=%b after A3 recover, expected 1", incno_w[0]);
    end
    fifoempty = 1'b1;
    serve_byte(0, 8'hB0, 2'd0, 2, "b2b_b0");
    checks++;
    if (idle_cnt[0] != 0) begin
      errors++; $display("FAIL b2b_no_idle_gap: got %0d idle cycles, expected 0", idle_cnt[0]);
    end
    serve_byte(0, 8'hB1, 2'd1, 2, "b2b_b1");
    serve_byte(0, 8'hB2, 2'd2, 2, "b2b_b2");
    serve_byte(0, 8'hB3, 2'd3, 2, "b2b_b3");
    dreq = 1'b0;
    tick(); tick();
    checks++;
    if (incno_cnt[0] != 2 || busy_w[0] !== 1'b0) begin
      errors++; $display("FAIL b2b_end: incno_cnt=%0d busy=%b, expected 2/0", incno_cnt[0], busy_w[0]);
    end
  endtask

  task automatic test_pause();
    int incno_snap;
    int dack_snap;
    do_reset();
    enable = 1'b1; fifo_od = 32'hC0C1C2C3; fifoempty = 1'b0;
    tick();
    fifoempty = 1'b1;
    tick();
    serve_byte(0, 8'hC0, 2'd0, 2, "pause_b0");
    serve_byte(0, 8'hC1, 2'd1, 2, "pause_b1");
    enable = 1'b0;
    fifoempty = 1'b0;
    incno_snap = incno_cnt[0];
    dack_snap  = dack_cnt[0];
    repeat (20) tick();
    checks++;
    if (dack_cnt[0] != dack_snap || incno_cnt[0] != incno_snap) begin
      errors++;
      $display("FAIL pause_quiet: dack cycles %0d incno %0d during pause, expected 0/0",
               dack_cnt[0] - dack_snap, incno_cnt[0] - incno_snap);
    end
    checks++;
    if (bo_w[0] !== 2'd2 || pd_w[0] !== 8'hC2) begin
      errors++; $display("FAIL pause_hold: bo=%0d pd=%h, expected 2/c2", bo_w[0], pd_w[0]);
    end
    fifoempty = 1'b1;
    enable = 1'b1;
    serve_byte(0, 8'hC2, 2'd2, 2, "pause_b2");
    serve_byte(0, 8'hC3, 2'd3, 2, "pause_b3");
    dreq = 1'b0;
    tick();
    checks++;
    if (incno_cnt[0] != 1) begin
      errors++; $display("FAIL pause_incno_count: got %0d, expected 1", incno_cnt[0]);
    end
  endtask

  task automatic test_flush_in_strobe();
    int dack_snap;
    do_reset();
    enable = 1'b1; fifo_od = 32'hD0D1D2D3; fifoempty = 1'b0;
    tick();
    fifoempty = 1'b1;
    tick();
    dreq = 1'b1;
    tick();
    checks++;
    if (dack_w[1] !== 1'b1) begin errors++; $display("FAIL flush_dack_c1: got %b, expected 1", dack_w[1]); end
    tick();
    flush = 1'b1;
    checks++;
    if (dack_w[1] !== 1'b1) begin errors++; $display("FAIL flush_dack_c2: got %b, expected 1", dack_w[1]); end
    tick();
    flush = 1'b0;
    checks++;
    if (dack_w[1] !== 1'b1) begin errors++; $display("FAIL flush_dack_c3: got %b, expected 1", dack_w[1]); end
    tick();
    checks++;
    if (dack_w[1] !== 1'b0 || busy_w[1] !== 1'b0 || pd_w[1] !== 8'h00 || bo_w[1] !== 2'd0) begin
      errors++;
      $display("FAIL flush_after: dack=%b busy=%b pd=%h bo=%0d, expected 0/0/00/0",
               dack_w[1], busy_w[1], pd_w[1], bo_w[1]);
    end
    dack_snap = dack_cnt[1];
    repeat (8) tick();
    checks++;
    if (dack_cnt[1] != dack_snap) begin
      errors++; $display("FAIL flush_no_more_dack: got %0d extra dack cycles, expected 0", dack_cnt[1] - dack_snap);
    end
    dreq = 1'b0;
  endtask

  task automatic test_reset_mid_strobe();
    do_reset();
    enable = 1'b1; fifo_od = 32'hE0E1E2E3; fifoempty = 1'b0;
    tick();
    fifoempty = 1'b1;
    tick();
    dreq = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if (dack_w[0] !== 1'b0 || busy_w[0] !== 1'b0 || pd_w[0] !== 8'h00 ||
        bo_w[0] !== 2'd0 || incno_w[0] !== 1'b0 || boeq3_w[0] !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_outputs: dack=%b busy=%b pd=%h bo=%0d incno=%b, expected 0/0/00/0/0",
               dack_w[0], busy_w[0], pd_w[0], bo_w[0], incno_w[0]);
    end
    rst = 1'b0; dreq = 1'b0; fifo_od = 32'hF0F1F2F3; fifoempty = 1'b0;
    tick();
    checks++;
    if (incno_w[0] !== 1'b1) begin errors++; $display("FAIL rstmid_reload: incno=%b, expected 1", incno_w[0]); end
    fifoempty = 1'b1;
    tick();
    checks++;
    if (pd_w[0] !== 8'hF0 || bo_w[0] !== 2'd0) begin
      errors++; $display("FAIL rstmid_fresh_word: pd=%h bo=%0d, expected f0/0", pd_w[0], bo_w[0]);
    end
  endtask

  task automatic test_param_sweep();
    do_reset();
    enable = 1'b1; fifo_od = 32'h5A6B7C8D; fifoempty = 1'b0;
    tick();
    fifoempty = 1'b1;
    tick();
    serve_byte(2, 8'h5A, 2'd0, 1, "w1_b0");
    serve_byte(2, 8'h6B, 2'd1, 1, "w1_b1");
    dreq = 1'b0;
    do_reset();
    enable = 1'b1; fifo_od = 32'h5A6B7C8D; fifoempty = 1'b0;
    tick();
    fifoempty = 1'b1;
    tick();
    serve_byte(3, 8'h5A, 2'd0, 15, "w15_b0");
    serve_byte(3, 8'h6B, 2'd1, 15, "w15_b1");
    dreq = 1'b0;
    tick();
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      incno_cnt[i] = 0; dack_cnt[i] = 0; idle_cnt[i] = 0;
    end
    test_reset();
    test_single_word();
    test_back_to_back();
    test_pause();
    test_flush_in_strobe();
    test_reset_mid_strobe();
    test_param_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
